// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_pkg                                                         |
// | Brief    : shared constants, state encoding and helpers for the CIC        |
// |            interpolator                                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cic_pkg;

    localparam int MAX_OS_LOG2 = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cic_state_e;

    // os_sel values above MAX_OS_LOG2 are folded onto the largest ratio
    function automatic logic [2:0] clamp_os_sel(input logic [2:0] sel);
        return (int'(sel) > MAX_OS_LOG2) ? 3'(MAX_OS_LOG2) : sel;
    endfunction

    function automatic logic [6:0] ratio_minus1(input logic [2:0] sel);
        logic [6:0] r;
        r = 7'd1 << clamp_os_sel(sel);
        return r - 7'd1;
    endfunction

    function automatic int cic_iw(input int dw, input int stages);
        return dw + stages * 6;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_int_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_int_stage                                                   |
// | Brief    : one modulo-2^IW integrator register with enable                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cic_int_stage #(
    parameter int IW = 28
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_en,
    input  logic [IW-1:0] i_din,
    output logic [IW-1:0] o_acc
);

    logic [IW-1:0] r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_din;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/cic_interpolator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_interpolator                                                |
// | Brief    : N-stage CIC interpolator, ratio 2^os_sel, valid/ready input,    |
// |            one normalized sample per clk. Option: CIC_INTP_ROUND_EN        |
// |            (round-half-up + saturate in the normalizer).                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int DW     = 16,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    os_sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    output logic [DW-1:0] data_out,
    output logic          underrun
);

    localparam int IW = cic_iw(DW, STAGES);

    cic_state_e    r_state;
    cic_state_e    w_state_next;
    logic [2:0]    r_sel;
    logic [5:0]    r_phase;
    logic          w_phase_last;
    logic          w_ready;
    logic          w_accept;
    logic          w_miss;
    logic          w_slot;
    logic          r_underrun;

    logic [IW-1:0] r_dly      [STAGES];
    logic [IW-1:0] w_dly_next [STAGES];
    logic [IW-1:0] w_comb_out;
    logic [IW-1:0] r_comb_q;
    logic          r_stuff;
    logic [IW-1:0] w_y        [STAGES];

    logic [DW-1:0] r_data_out;
    logic [DW-1:0] w_norm;

    assign w_phase_last = ({1'b0, r_phase} == ratio_minus1(r_sel));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_phase_last) begin
                    w_ready = 1'b1;
                    if (in_valid) begin
                        w_accept = 1'b1;
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_slot   = w_accept | w_miss;
    // Gated so in_ready reads 0 while reset is held, not the IDLE value
    assign in_ready = w_ready & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel      <= '0;
            r_phase    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_miss;
            if (w_accept) begin
                r_sel <= clamp_os_sel(os_sel);
            end
            if (w_slot) begin
                r_phase <= '0;
            end else if (r_state == RUN) begin
                r_phase <= r_phase + 6'd1;
            end
        end
    end

    // Comb chain; a missed slot pushes a zero sample through it
    always_comb begin : p_comb
        logic [IW-1:0] v_acc;
        v_acc = w_accept ? {{(IW-DW){data_in[DW-1]}}, data_in} : '0;
        for (int k = 0; k < STAGES; k++) begin
            w_dly_next[k] = v_acc;
            v_acc         = v_acc - r_dly[k];
        end
        w_comb_out = v_acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_dly[k] <= '0;
            end
            r_comb_q <= '0;
            r_stuff  <= 1'b0;
        end else begin
            r_stuff <= w_slot;
            if (w_slot) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_dly[k] <= w_dly_next[k];
                end
                r_comb_q <= w_comb_out;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_int
        logic [IW-1:0] w_din;
        if (k == 0) begin : g_first
            assign w_din = r_stuff ? r_comb_q : '0;
        end else begin : g_chain
            assign w_din = w_y[k-1];
        end
        cic_int_stage #(
            .IW(IW)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .i_en    (r_state == RUN),
            .i_din   (w_din),
            .o_acc   (w_y[k])
        );
    end

    logic [4:0]           w_sh;
    logic signed [IW-1:0] w_y_last;
    logic signed [IW-1:0] w_shifted;

    assign w_sh     = 5'((STAGES - 1) * int'(r_sel));
    assign w_y_last = w_y[STAGES-1];

`ifdef CIC_INTP_ROUND_EN
    localparam logic signed [IW-1:0] c_sat_max = IW'((2 ** (DW - 1)) - 1);
    localparam logic signed [IW-1:0] c_sat_min = IW'(-(2 ** (DW - 1)));

    logic signed [IW-1:0] w_rnd;
    logic signed [IW-1:0] w_sum;

    assign w_rnd     = (w_sh == 5'd0) ? '0 : (IW'(1) << (w_sh - 5'd1));
    assign w_sum     = w_y_last + w_rnd;
    assign w_shifted = w_sum >>> w_sh;

    always_comb begin
        w_norm = DW'(w_shifted);
        if (w_shifted > c_sat_max) begin
            w_norm = DW'(c_sat_max);
        end else if (w_shifted < c_sat_min) begin
            w_norm = DW'(c_sat_min);
        end
    end
`else
    assign w_shifted = w_y_last >>> w_sh;
    assign w_norm    = DW'(w_shifted);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
        end else if (r_state == RUN) begin
            r_data_out <= w_norm;
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = (r_state == RUN);
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cic_interpolator                                             |
// | Brief    : scoreboard bench for cic_interpolator (DW=16, STAGES=2)         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cic_interpolator;

    localparam int N = 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [2:0]  os_sel   = 3'd0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in  = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] data_out;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    bit chk_data = 1'b1;

    int          m_state = 0;
    int          m_phase = 0;
    int          m_sel   = 0;
    int          cyc     = 0;
    bit          m_und   = 1'b0;
    longint      u_hist [256];
    logic [15:0] exp_q [$];

    cic_interpolator #(.DW(16), .STAGES(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .os_sel    (os_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    function automatic int clamp_sel(input logic [2:0] s);
        return (s > 3'd6) ? 6 : int'(s);
    endfunction

    function automatic logic [15:0] norm(input longint full, input int sh);
        longint v;
`ifdef CIC_INTP_ROUND_EN
        v = full + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 64'sd0);
        v = v >>> sh;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`else
        v = full >>> sh;
`endif
        return 16'(v);
    endfunction

    // Reference: zero-stuffed input convolved with the triangular N=2 response
    always @(negedge clk) begin
        int          r;
        bit          nund;
        longint      x;
        longint      full;
        logic [15:0] e;
        if (!reset_n) begin
            checks++;
            if (data_out !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || underrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got data_out=%0d out_valid=%b in_ready=%b underrun=%b, want all 0",
                         data_out, out_valid, in_ready, underrun);
            end
            m_state = 0; m_phase = 0; m_sel = 0; cyc = 0; m_und = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 256; i++) u_hist[i] = 0;
        end else begin
            r = 1 << m_sel;
            checks++;
            if (in_ready !== logic'((m_state == 0) || (m_phase == r - 1))) begin
                errors++;
                $display("FAIL in_ready: got %b want %b (phase %0d)", in_ready, (m_state == 0) || (m_phase == r - 1), m_phase);
            end
            checks++;
            if (underrun !== logic'(m_und)) begin
                errors++;
                $display("FAIL underrun: got %b want %b", underrun, m_und);
            end
            checks++;
            if (out_valid !== logic'(m_state == 1)) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", out_valid, m_state == 1);
            end
            if (m_state == 1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got data_out=%0d with no expected entry", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (chk_data) begin
                        checks++;
                        if (data_out !== e) begin
                            errors++;
                            $display("FAIL data_out: got %0d want %0d at t=%0t", $signed(data_out), $signed(e), $time);
                        end
                    end
                end
            end else begin
                checks++;
                if (data_out !== 16'd0) begin
                    errors++;
                    $display("FAIL idle_data_out: got %0d want 0", data_out);
                end
            end
            nund = 1'b0;
            x    = 0;
            if (m_state == 0) begin
                if (in_valid) begin
                    x       = longint'($signed(data_in));
                    m_sel   = clamp_sel(os_sel);
                    m_state = 1;
                    m_phase = 0;
                    exp_q.delete();
                    repeat (N + 1) exp_q.push_back(16'd0);
                end
            end else if (m_phase == r - 1) begin
                m_phase = 0;
                if (in_valid) begin
                    x     = longint'($signed(data_in));
                    m_sel = clamp_sel(os_sel);
                end else begin
                    nund = 1'b1;
                end
            end else begin
                m_phase++;
            end
            m_und = nund;
            if (m_state == 1) begin
                r = 1 << m_sel;
                u_hist[cyc % 256] = x;
                full = 0;
                for (int k = 0; k < 2 * r - 1; k++) begin
                    if (cyc >= k) full += longint'((k < r) ? (k + 1) : (2 * r - 1 - k)) * u_hist[(cyc - k) % 256];
                end
                exp_q.push_back(norm(full, (N - 1) * m_sel));
                cyc++;
            end
        end
    end

    task automatic apply_reset;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 16'd0) begin
            errors++;
            $display("FAIL test_reset_idle: got in_ready=%b out_valid=%b data_out=%0d, want 1/0/0", in_ready, out_valid, data_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dc;
        int idx [$];
        apply_reset();
        os_sel = 3'd2; data_in = 16'd1000; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) idx.push_back(i);
            if (i == 12 || i == 39) begin
                checks++;
                if (data_out !== 16'd1000) begin
                    errors++;
                    $display("FAIL dc_settle: got %0d want 1000 at cycle %0d", data_out, i);
                end
            end
        end
        checks++;
        if (idx.size() != 10 || idx[2] - idx[1] != 4) begin
            errors++;
            $display("FAIL dc_ready_spacing: got %0d pulses, want 10 spaced by 4", idx.size());
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_impulse;
        logic [15:0] want [4];
        want[0] = 16'd128; want[1] = 16'd256; want[2] = 16'd128; want[3] = 16'd0;
        apply_reset();
        os_sel = 3'd1; data_in = 16'd256; in_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 16'd0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (data_out !== want[i]) begin
                errors++;
                $display("FAIL impulse_tap%0d: got %0d want %0d", i, data_out, want[i]);
            end
        end
        repeat (6) @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_underrun;
        bit found = 1'b0;
        int pulses = 0;
        int drops = 0;
        apply_reset();
        os_sel = 3'd3; data_in = 16'd500; in_valid = 1'b1;
        repeat (30) @(posedge clk);
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (in_ready) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL underrun_slot_timeout: got no in_ready within 20 clks, want one");
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (underrun) pulses++;
            if (!out_valid) drops++;
        end
        checks++;
        if (pulses != 1 || drops != 0) begin
            errors++;
            $display("FAIL underrun_pulse: got pulses=%0d out_valid_drops=%0d, want 1 and 0", pulses, drops);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_ratio_change;
        bit found = 1'b0;
        int idx [$];
        apply_reset();
        chk_data = 1'b0;
        os_sel = 3'd2; data_in = 16'd100; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (in_ready) found = 1'b1;
        end
        @(posedge clk); #1;
        os_sel = 3'd4;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) idx.push_back(i);
        end
        checks++;
        if (!found || idx.size() < 2 || idx[0] != 3 || idx[1] - idx[0] != 16) begin
            errors++;
            $display("FAIL ratio_change: got first=%0d gap=%0d, want 3 and 16",
                     (idx.size() > 0) ? idx[0] : -1, (idx.size() > 1) ? idx[1] - idx[0] : -1);
        end
        @(posedge clk); #1;
        apply_reset();
        chk_data = 1'b1;
    endtask

    task automatic test_full_scale;
        apply_reset();
        os_sel = 3'd6; data_in = 16'h8000; in_valid = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_out !== 16'h8000) begin
            errors++;
            $display("FAIL full_scale_neg: got %0d want -32768", $signed(data_out));
        end
        @(posedge clk); #1;
        data_in = 16'h7fff;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_out !== 16'h7fff) begin
            errors++;
            $display("FAIL full_scale_pos: got %0d want 32767", $signed(data_out));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_ratio_one;
        apply_reset();
        os_sel = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_random_gaps;
        apply_reset();
        os_sel = 3'd1;
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        apply_reset();
        os_sel = 3'd2; data_in = 16'd2000; in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (data_out !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got data_out=%0d out_valid=%b in_ready=%b, want 0/0/0", data_out, out_valid, in_ready);
        end
        @(posedge clk); #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_underrun();
        test_ratio_change();
        test_full_scale();
        test_ratio_one();
        test_random_gaps();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
